guvm_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares one 128-bit Wishbone slave port between the amber core's bus master (m0) and the GUVM stimulus/backdoor master (m1). It grants the bus round-robin, locks the grant for the whole `cyc` burst, and gates `ack`/`err` back to the owning master only. An optional watchdog aborts transfers the slave never answers. It sits between the core's `o_wb_*`/`i_wb_*` ports and the bench memory model.

---
 rtl/guvm_wb_pkg.sv | 27 ++
 rtl/guvm_wb_watchdog.sv | 68 ++++++
 rtl/guvm_wb_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_guvm_wb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guvm_wb_pkg.sv
// guvm_wb_pkg: shared types and constants for the two-master Wishbone arbiter.
// The NOP fill word is also used by the bench as the idle read-data pattern.
package guvm_wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 128;

  // amber NOP instruction, used to fill unused read data
  localparam logic [31:0] WB_NOP_FILL = 32'hF0801003;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_BUSY  = 2'd1,
    WB_ABORT = 2'd2
  } wb_state_e;

  // Round-robin pointer after the one-hot owner leaves: 1 means m1 is preferred next.
  function automatic logic wb_next_rr(input logic [1:0] grant);
    return grant[0];
  endfunction

  // Full data-bus word filled with NOP instructions.
  function automatic logic [WB_DAT_W-1:0] wb_nop_line();
    return {(WB_DAT_W / 32){WB_NOP_FILL}};
  endfunction

endpackage

// File: rtl/guvm_wb_watchdog.sv
// guvm_wb_watchdog: counts strobed cycles without a slave response, fires
// when the count reaches TIMEOUT and keeps a saturating count of aborts.
// Only instantiated when GUVM_WB_TIMEOUT_EN is defined.
module guvm_wb_watchdog
  import guvm_wb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_busy,
  input  logic       i_stb,
  input  logic       i_resp,
  input  logic       i_release,
  output logic       o_fire,
  output logic [7:0] o_abort_cnt
);

  // Fires while the count already holds TIMEOUT-1 and another silent strobe cycle passes.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] abort_cnt_q, abort_cnt_d;

  // Silent-cycle counter: counts strobes without response, clears on response or state change.
  always_comb begin
    cnt_d  = 8'd0;
    o_fire = 1'b0;
    if (i_busy && !i_release && !i_resp) begin
      if (i_stb) begin
        if (cnt_q == LAST_CNT) begin
          o_fire = 1'b1;
          cnt_d  = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = 8'd0;
    end
  end

  // Abort counter: one step per fire, saturating at 255.
  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (o_fire && (abort_cnt_q != 8'hFF)) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end else begin
      abort_cnt_d = abort_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q       <= 8'd0;
      abort_cnt_q <= 8'd0;
    end else begin
      cnt_q       <= cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign o_abort_cnt = abort_cnt_q;

endmodule

// File: rtl/guvm_wb_arbiter.sv
// guvm_wb_arbiter: shares one Wishbone slave between the amber core (m0) and
// the GUVM master (m1). Round-robin grant on contention, grant held for the
// whole cyc burst, responses routed to the owner only.
// Optional watchdog abort: define GUVM_WB_TIMEOUT_EN.
module guvm_wb_arbiter
  import guvm_wb_pkg::*;
#(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [ADR_W-1:0]   i_m0_wb_adr,
  input  logic [DAT_W/8-1:0] i_m0_wb_sel,
  input  logic               i_m0_wb_we,
  input  logic [DAT_W-1:0]   i_m0_wb_dat,
  input  logic               i_m0_wb_cyc,
  input  logic               i_m0_wb_stb,
  output logic [DAT_W-1:0]   o_m0_wb_dat,
  output logic               o_m0_wb_ack,
  output logic               o_m0_wb_err,
  input  logic [ADR_W-1:0]   i_m1_wb_adr,
  input  logic [DAT_W/8-1:0] i_m1_wb_sel,
  input  logic               i_m1_wb_we,
  input  logic [DAT_W-1:0]   i_m1_wb_dat,
  input  logic               i_m1_wb_cyc,
  input  logic               i_m1_wb_stb,
  output logic [DAT_W-1:0]   o_m1_wb_dat,
  output logic               o_m1_wb_ack,
  output logic               o_m1_wb_err,
  output logic [ADR_W-1:0]   o_s_wb_adr,
  output logic [DAT_W/8-1:0] o_s_wb_sel,
  output logic               o_s_wb_we,
  output logic [DAT_W-1:0]   o_s_wb_dat,
  output logic               o_s_wb_cyc,
  output logic               o_s_wb_stb,
  input  logic [DAT_W-1:0]   i_s_wb_dat,
  input  logic               i_s_wb_ack,
  input  logic               i_s_wb_err,
  output logic [1:0]         o_grant,
  output logic [7:0]         o_timeout_cnt
);

  // Elaboration-time guard on the watchdog limit.
  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("guvm_wb_arbiter: TIMEOUT must lie in 2..255");
  end

  wb_state_e  state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_q, rr_d;
  logic       owner_cyc_s;
  logic       resp_ack_s;
  logic       wd_fire_s;
  logic       abort_entry_s;

  // owner is m1 when grant_q[1] is set, otherwise m0
  assign owner_cyc_s = grant_q[1] ? i_m1_wb_cyc : i_m0_wb_cyc;
  // err wins over ack when the slave drives both
  assign resp_ack_s  = i_s_wb_ack & ~i_s_wb_err;

`ifdef GUVM_WB_TIMEOUT_EN
  logic abort_entry_q, abort_entry_d;

  guvm_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_busy      (state_q == WB_BUSY),
    .i_stb       (o_s_wb_stb),
    .i_resp      (i_s_wb_ack | i_s_wb_err),
    .i_release   (!owner_cyc_s),
    .o_fire      (wd_fire_s),
    .o_abort_cnt (o_timeout_cnt)
  );

  // Flags the single cycle in which the aborted owner receives err.
  always_comb begin
    abort_entry_d = (state_q == WB_BUSY) && (state_d == WB_ABORT);
  end

  // Abort-entry flag register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      abort_entry_q <= 1'b0;
    end else begin
      abort_entry_q <= abort_entry_d;
    end
  end

  assign abort_entry_s = abort_entry_q;
`else
  assign wd_fire_s     = 1'b0;
  assign abort_entry_s = 1'b0;
  assign o_timeout_cnt = 8'd0;
`endif

  // Next-state: arbitration in IDLE, release/abort from BUSY, release from ABORT.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      WB_IDLE: begin
        if (i_m0_wb_cyc && (!i_m1_wb_cyc || !rr_q)) begin
          state_d = WB_BUSY;
          grant_d = 2'b01;
        end else if (i_m1_wb_cyc) begin
          state_d = WB_BUSY;
          grant_d = 2'b10;
        end else begin
          state_d = WB_IDLE;
        end
      end
      WB_BUSY: begin
        if (!owner_cyc_s) begin
          state_d = WB_IDLE;
          grant_d = 2'b00;
          rr_d    = wb_next_rr(grant_q);
        end else if (wd_fire_s) begin
          state_d = WB_ABORT;
        end else begin
          state_d = WB_BUSY;
        end
      end
      WB_ABORT: begin
        if (!owner_cyc_s) begin
          state_d = WB_IDLE;
          grant_d = 2'b00;
          rr_d    = wb_next_rr(grant_q);
        end else begin
          state_d = WB_ABORT;
        end
      end
      default: begin
        state_d = WB_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= WB_IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Slave-side mux and response routing; everything is zero unless BUSY.
  always_comb begin
    o_s_wb_adr  = {ADR_W{1'b0}};
    o_s_wb_sel  = {(DAT_W/8){1'b0}};
    o_s_wb_we   = 1'b0;
    o_s_wb_dat  = {DAT_W{1'b0}};
    o_s_wb_cyc  = 1'b0;
    o_s_wb_stb  = 1'b0;
    o_m0_wb_ack = 1'b0;
    o_m0_wb_err = 1'b0;
    o_m1_wb_ack = 1'b0;
    o_m1_wb_err = 1'b0;
    case (state_q)
      WB_BUSY: begin
        if (grant_q[1]) begin
          o_s_wb_adr  = i_m1_wb_adr;
          o_s_wb_sel  = i_m1_wb_sel;
          o_s_wb_we   = i_m1_wb_we;
          o_s_wb_dat  = i_m1_wb_dat;
          o_s_wb_cyc  = i_m1_wb_cyc;
          o_s_wb_stb  = i_m1_wb_stb;
          o_m1_wb_ack = resp_ack_s;
          o_m1_wb_err = i_s_wb_err;
        end else begin
          o_s_wb_adr  = i_m0_wb_adr;
          o_s_wb_sel  = i_m0_wb_sel;
          o_s_wb_we   = i_m0_wb_we;
          o_s_wb_dat  = i_m0_wb_dat;
          o_s_wb_cyc  = i_m0_wb_cyc;
          o_s_wb_stb  = i_m0_wb_stb;
          o_m0_wb_ack = resp_ack_s;
          o_m0_wb_err = i_s_wb_err;
        end
      end
      WB_ABORT: begin
        if (abort_entry_s) begin
          o_m1_wb_err = grant_q[1];
          o_m0_wb_err = ~grant_q[1];
        end else begin
          o_m0_wb_err = 1'b0;
        end
      end
      WB_IDLE: begin
        o_s_wb_cyc = 1'b0;
      end
      default: begin
        o_s_wb_cyc = 1'b0;
      end
    endcase
  end

  assign o_m0_wb_dat = i_s_wb_dat;
  assign o_m1_wb_dat = i_s_wb_dat;
  assign o_grant     = grant_q;

endmodule

// File: tb/tb_guvm_wb_arbiter.sv
// tb_guvm_wb_arbiter: directed scenarios plus a randomized phase, all checked
// every cycle against a transaction-level model of ownership, round-robin
// preference and the watchdog. Build with GUVM_WB_TIMEOUT_EN to cover aborts.
module tb_guvm_wb_arbiter;
  import guvm_wb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = DW / 8;
  localparam int TO = 8;
`ifdef GUVM_WB_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m_adr [2];
  logic [SW-1:0] m_sel [2];
  logic          m_we  [2];
  logic [DW-1:0] m_dat [2];
  logic          m_cyc [2];
  logic          m_stb [2];
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err;

  logic [DW-1:0] o_m0_dat, o_m1_dat;
  logic          o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic [AW-1:0] o_s_adr;
  logic [SW-1:0] o_s_sel;
  logic          o_s_we, o_s_cyc, o_s_stb;
  logic [DW-1:0] o_s_dat;
  logic [1:0]    o_grant;
  logic [7:0]    o_tcnt;

  always #5 clk = ~clk;

  guvm_wb_arbiter #(.ADR_W(AW), .DAT_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_wb_adr(m_adr[0]), .i_m0_wb_sel(m_sel[0]), .i_m0_wb_we(m_we[0]),
    .i_m0_wb_dat(m_dat[0]), .i_m0_wb_cyc(m_cyc[0]), .i_m0_wb_stb(m_stb[0]),
    .o_m0_wb_dat(o_m0_dat), .o_m0_wb_ack(o_m0_ack), .o_m0_wb_err(o_m0_err),
    .i_m1_wb_adr(m_adr[1]), .i_m1_wb_sel(m_sel[1]), .i_m1_wb_we(m_we[1]),
    .i_m1_wb_dat(m_dat[1]), .i_m1_wb_cyc(m_cyc[1]), .i_m1_wb_stb(m_stb[1]),
    .o_m1_wb_dat(o_m1_dat), .o_m1_wb_ack(o_m1_ack), .o_m1_wb_err(o_m1_err),
    .o_s_wb_adr(o_s_adr), .o_s_wb_sel(o_s_sel), .o_s_wb_we(o_s_we),
    .o_s_wb_dat(o_s_dat), .o_s_wb_cyc(o_s_cyc), .o_s_wb_stb(o_s_stb),
    .i_s_wb_dat(s_dat), .i_s_wb_ack(s_ack), .i_s_wb_err(s_err),
    .o_grant(o_grant), .o_timeout_cnt(o_tcnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // reference model: who owns the bus, who is preferred next, watchdog bookkeeping
  int m_owner;   // -1 = nobody, else master index
  int m_rr;      // master preferred when both request
  int m_wcnt;    // strobed cycles without response
  int m_tcnt;    // aborts so far
  bit m_abort;   // owner has been aborted, waiting for it to drop cyc
  bit m_entry;   // first cycle of an abort

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_wcnt = 0; m_tcnt = 0; m_abort = 1'b0; m_entry = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    int o;
    m_entry = 1'b0;
    if (m_owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) m_owner = m_rr;
      else if (m_cyc[0])        m_owner = 0;
      else if (m_cyc[1])        m_owner = 1;
      m_wcnt = 0;
    end else begin
      o = m_owner;
      if (!m_cyc[o]) begin
        m_rr = 1 - o; m_owner = -1; m_abort = 1'b0; m_wcnt = 0;
      end else if (!m_abort) begin
        if (s_ack || s_err) m_wcnt = 0;
        else if (m_stb[o]) begin
          m_wcnt++;
          if (WD_EN && m_wcnt == TO) begin
            m_abort = 1'b1; m_entry = 1'b1; m_wcnt = 0;
            if (m_tcnt < 255) m_tcnt++;
          end
        end
      end
    end
  endtask

  // Compare every DUT output against what the model says this cycle.
  task automatic check_all();
    logic [1:0] eg, e_ack, e_err;
    bit busy;
    int o;
    logic e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [SW-1:0] e_sel;
    logic [DW-1:0] e_dat;
    eg = 2'b00; e_ack = 2'b00; e_err = 2'b00; busy = 1'b0; o = 0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_sel = '0; e_dat = '0;
    if (m_owner >= 0) begin
      o = m_owner;
      eg = (o == 0) ? 2'b01 : 2'b10;
      busy = !m_abort;
    end
    if (busy) begin
      e_cyc = m_cyc[o]; e_stb = m_stb[o]; e_we = m_we[o];
      e_adr = m_adr[o]; e_sel = m_sel[o]; e_dat = m_dat[o];
      e_ack[o] = s_ack && !s_err;
      e_err[o] = s_err;
    end
    if (m_owner >= 0 && m_abort && m_entry) e_err[o] = 1'b1;
    chk("grant",  o_grant,  eg);
    chk("s_cyc",  o_s_cyc,  e_cyc);
    chk("s_stb",  o_s_stb,  e_stb);
    chk("s_we",   o_s_we,   e_we);
    chk("s_adr",  o_s_adr,  e_adr);
    chk("s_sel",  o_s_sel,  e_sel);
    chk("s_dat",  o_s_dat,  e_dat);
    chk("m0_ack", o_m0_ack, e_ack[0]);
    chk("m0_err", o_m0_err, e_err[0]);
    chk("m1_ack", o_m1_ack, e_ack[1]);
    chk("m1_err", o_m1_err, e_err[1]);
    chk("m0_dat", o_m0_dat, s_dat);
    chk("m1_dat", o_m1_dat, s_dat);
    chk("tcnt",   o_tcnt,   m_tcnt[7:0]);
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    cyc_no++;
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_sel[i] = '0; m_we[i] = 1'b0; m_dat[i] = '0;
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
    end
    s_dat = wb_nop_line(); s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    settle();
    #2 rst_n = 1'b1;
    adv();
    cyc_no = 0;
  endtask

  task automatic rand_master(input int i);
    m_adr[i] = $urandom; m_sel[i] = {$urandom, $urandom} & 16'hFFFF;
    m_we[i] = 1'($urandom_range(1)); m_dat[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    bit drop [2];
    bit nxt_drop [2];
    logic [1:0] prev_g;
    int exp_owner, n_hand;

    // ---- reset values
    do_reset();
    chk("rst_grant", o_grant, 2'b00);
    chk("rst_s_cyc", o_s_cyc, 1'b0);
    chk("rst_tcnt",  o_tcnt,  8'd0);

    // ---- single master, slave acks in cycle 3, m0 releases in cycle 4
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h100; m_sel[0] = 16'hFFFF;
    for (int c = 0; c < 6; c++) begin
      s_ack = (c == 3);
      if (c >= 4) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      settle();
      if (c == 0) chk("single_grant_c0", o_grant, 2'b00);
      if (c == 1) chk("single_grant_c1", o_grant, 2'b01);
      if (c == 1) chk("single_adr_c1", o_s_adr, 32'h100);
      chk("single_m0_ack", o_m0_ack, (c == 3));
      chk("single_m1_ack", o_m1_ack, 1'b0);
      adv();
    end

    // ---- simultaneous request after reset, m0 first; collision while m1 owns
    do_reset();
    for (int i = 0; i < 2; i++) begin m_cyc[i] = 1'b1; m_stb[i] = 1'b1; rand_master(i); end
    for (int c = 0; c < 11; c++) begin
      if (c >= 5) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      if (c >= 9) begin m_cyc[1] = 1'b0; m_stb[1] = 1'b0; end
      s_ack = (c == 8); s_err = (c == 8);
      settle();
      if (c == 1) chk("simul_grant_c1", o_grant, 2'b01);
      if (c == 6) chk("simul_grant_c6", o_grant, 2'b00);
      if (c == 7) chk("simul_grant_c7", o_grant, 2'b10);
      if (c == 8) begin
        chk("collide_m1_err", o_m1_err, 1'b1);
        chk("collide_m1_ack", o_m1_ack, 1'b0);
        chk("collide_m0_err", o_m0_err, 1'b0);
      end
      adv();
    end
    s_ack = 1'b0; s_err = 1'b0;

    // ---- fairness: both request continuously, each releases after one ack
    do_reset();
    drop[0] = 1'b0; drop[1] = 1'b0; prev_g = 2'b00; exp_owner = 0; n_hand = 0;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 2; i++) begin
        m_cyc[i] = !drop[i]; m_stb[i] = !drop[i]; rand_master(i);
      end
      #1;
      s_ack = o_s_stb;
      settle();
      if (o_grant != 2'b00 && prev_g == 2'b00) begin
        chk("fair_owner", o_grant, (exp_owner == 0) ? 2'b01 : 2'b10);
        exp_owner = 1 - exp_owner;
        n_hand++;
      end
      prev_g = o_grant;
      nxt_drop[0] = o_m0_ack; nxt_drop[1] = o_m1_ack;
      adv();
      drop[0] = nxt_drop[0]; drop[1] = nxt_drop[1];
    end
    chk("fair_handovers", n_hand, 20);

    // ---- watchdog: m0 strobes, slave silent; slave ack in cycle 9 must be ignored on abort
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h200;
    for (int c = 0; c < 14; c++) begin
      s_ack = (c == 9);
      if (c >= 12) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      settle();
`ifdef GUVM_WB_TIMEOUT_EN
      if (c == 8) begin
        chk("wd_err_c8", o_m0_err, 1'b0);
        chk("wd_stb_c8", o_s_stb, 1'b1);
      end
      if (c == 9) begin
        chk("wd_err_c9", o_m0_err, 1'b1);
        chk("wd_ack_c9", o_m0_ack, 1'b0);
        chk("wd_stb_c9", o_s_stb, 1'b0);
        chk("wd_tcnt_c9", o_tcnt, 8'd1);
      end
      if (c == 10) chk("wd_err_c10", o_m0_err, 1'b0);
`else
      if (c == 9) begin
        chk("nowd_ack_c9", o_m0_ack, 1'b1);
        chk("nowd_stb_c9", o_s_stb, 1'b1);
        chk("nowd_tcnt", o_tcnt, 8'd0);
      end
`endif
      adv();
    end
    s_ack = 1'b0;

    // ---- randomized traffic with occasional silent-slave stretches
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_cyc[i]) m_cyc[i] = ($urandom_range(5) != 0);
        else          m_cyc[i] = ($urandom_range(2) == 0);
        m_stb[i] = m_cyc[i] && ($urandom_range(3) != 0);
        rand_master(i);
      end
      s_dat = {$urandom, $urandom, $urandom, $urandom};
      if ((c % 100) < 14) begin
        s_ack = 1'b0; s_err = 1'b0;
      end else begin
        s_ack = ($urandom_range(2) == 0); s_err = ($urandom_range(7) == 0);
      end
      settle();
      adv();
    end

    // ---- asynchronous reset while m0 owns the bus
    idle_inputs();
    for (int c = 0; c < 3; c++) begin settle(); adv(); end
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h300;
    settle();
    adv();
    settle();
    chk("arst_pre_cyc", o_s_cyc, 1'b1);
    @(posedge clk); model_edge(); cyc_no++;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s_cyc", o_s_cyc, 1'b0);
    chk("arst_s_stb", o_s_stb, 1'b0);
    chk("arst_grant", o_grant, 2'b00);
    chk("arst_tcnt",  o_tcnt,  8'd0);
    model_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    settle();
    #2 rst_n = 1'b1;
    adv();
    settle();
    chk("arst_rr_m0", o_grant, 2'b01);
    idle_inputs();
    adv();
    settle();
    adv();
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
